cmp_max_ctrl: RTL and testbench

- Sequencer that drives the shared 16-bit signed comparator (eq / ae / gt flag unit) to find the maximum of a streamed list of words.
- Accepts a length and a valid/ready word stream, and presents each word against the running maximum.
- Waits a fixed settling time, because the comparator is slow combinational logic, then samples the flags.
- Reports the maximum value, its index, a count of exact ties and a count of opposite-sign magnitude ties.

---
 rtl/cmp_max_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_cmp_max_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cmp_max_ctrl.sv
// Sequencer that streams words through a shared slow signed comparator and
// tracks the running maximum, its first index, exact ties and sign-opposite ties.
module cmp_max_ctrl #(
    parameter int CMP_WAIT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic [15:0]      cmp_a,
    output logic [15:0]      cmp_b,
    input  logic             cmp_eq,
    input  logic             cmp_ae,
    input  logic             cmp_gt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      max_val,
    output logic [CNT_W-1:0] max_idx,
    output logic [CNT_W-1:0] tie_cnt,
    output logic [CNT_W-1:0] neg_cnt
);

    localparam int WAIT_W = (CMP_WAIT > 1) ? $clog2(CMP_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(CMP_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_idx;
    logic [WAIT_W-1:0] r_wait;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [15:0]       r_cmp_a;
    logic [15:0]       r_cmp_b;
    logic [15:0]       r_max_val;
    logic [CNT_W-1:0]  r_max_idx;
    logic [CNT_W-1:0]  r_tie_cnt;
    logic [CNT_W-1:0]  r_neg_cnt;

    logic              w_xfer;
    logic [CNT_W-1:0]  w_idx_next;
    logic              w_last;
    logic [CNT_W-1:0]  w_tie_inc;
    logic [CNT_W-1:0]  w_neg_inc;

    assign w_xfer     = in_valid && r_in_ready;
    assign w_idx_next = r_idx + CNT_W'(1);
    assign w_last     = (w_idx_next == r_len);
    assign w_tie_inc  = (&r_tie_cnt) ? r_tie_cnt : r_tie_cnt + CNT_W'(1);
    assign w_neg_inc  = (&r_neg_cnt) ? r_neg_cnt : r_neg_cnt + CNT_W'(1);

    // Operands stay frozen from the FETCH that loads them until DECIDE samples the flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_idx      <= '0;
            r_wait     <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cmp_a    <= '0;
            r_cmp_b    <= '0;
            r_max_val  <= '0;
            r_max_idx  <= '0;
            r_tie_cnt  <= '0;
            r_neg_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx     <= '0;
                        r_max_val <= '0;
                        r_max_idx <= '0;
                        r_tie_cnt <= '0;
                        r_neg_cnt <= '0;
                        r_busy    <= 1'b1;
                        if (len != '0) begin
                            r_len      <= len;
                            r_in_ready <= 1'b1;
                            r_err      <= 1'b0;
                            r_state    <= S_FETCH;
                        end else begin
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    if (w_xfer) begin
                        if (r_idx == '0) begin
                            r_max_val <= in_data;
                            r_max_idx <= '0;
                            r_tie_cnt <= CNT_W'(1);
                            r_neg_cnt <= '0;
                            r_idx     <= CNT_W'(1);
                            if (r_len == CNT_W'(1)) begin
                                r_in_ready <= 1'b0;
                                r_done     <= 1'b1;
                                r_state    <= S_DONE;
                            end
                        end else begin
                            r_cmp_a    <= in_data;
                            r_cmp_b    <= r_max_val;
                            r_wait     <= WAIT_LOAD;
                            r_in_ready <= 1'b0;
                            r_state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait == '0) begin
                        r_state <= S_DECIDE;
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                S_DECIDE: begin
                    // gt takes priority so an illegal gt+eq pair still yields a consistent max.
                    if (cmp_gt) begin
                        r_max_val <= r_cmp_a;
                        r_max_idx <= r_idx;
                        r_tie_cnt <= CNT_W'(1);
                        r_neg_cnt <= '0;
                    end else if (cmp_eq) begin
                        r_tie_cnt <= w_tie_inc;
                    end else if (cmp_ae) begin
                        r_neg_cnt <= w_neg_inc;
                    end
                    r_idx <= w_idx_next;
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_err      <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign cmp_a    = r_cmp_a;
    assign cmp_b    = r_cmp_b;
    assign max_val  = r_max_val;
    assign max_idx  = r_max_idx;
    assign tie_cnt  = r_tie_cnt;
    assign neg_cnt  = r_neg_cnt;

endmodule

// File: tb/tb_cmp_max_ctrl.sv
// Directed bench for cmp_max_ctrl: models the comparator, queues expected
// search results as each search is launched and checks them on done.
module tb_cmp_max_ctrl;

    localparam int CMP_WAIT = 4;
    localparam int CNT_W    = 8;

    typedef struct {
        logic [15:0]      maxVal;
        logic [CNT_W-1:0] maxIdx;
        logic [CNT_W-1:0] tieCnt;
        logic [CNT_W-1:0] negCnt;
        logic             err;
        int               latency;
    } expT;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             inValid;
    logic [15:0]      inData;
    logic             inReady;
    logic [15:0]      cmpA;
    logic [15:0]      cmpB;
    logic             cmpEq;
    logic             cmpAe;
    logic             cmpGt;
    logic             busy;
    logic             done;
    logic             err;
    logic [15:0]      maxVal;
    logic [CNT_W-1:0] maxIdx;
    logic [CNT_W-1:0] tieCnt;
    logic [CNT_W-1:0] negCnt;

    int          errors = 0;
    int          checks = 0;
    int          cycleCnt = 0;
    expT         expQ[$];
    logic [15:0] wq[$];

    cmp_max_ctrl #(.CMP_WAIT(CMP_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(inValid), .in_data(inData), .in_ready(inReady),
        .cmp_a(cmpA), .cmp_b(cmpB),
        .cmp_eq(cmpEq), .cmp_ae(cmpAe), .cmp_gt(cmpGt),
        .busy(busy), .done(done), .err(err),
        .max_val(maxVal), .max_idx(maxIdx), .tie_cnt(tieCnt), .neg_cnt(negCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    function automatic logic [16:0] abs17(input logic [15:0] x);
        logic signed [16:0] v;
        v = {x[15], x};
        return (v < 0) ? 17'(-v) : 17'(v);
    endfunction

    // Comparator reference driven straight from the DUT operands.
    assign cmpEq = (cmpA == cmpB);
    assign cmpAe = (abs17(cmpA) == abs17(cmpB));
    assign cmpGt = ($signed(cmpA) > $signed(cmpB));

    function automatic expT computeExpected(input int n, input bit bubble);
        expT e;
        e.maxVal = '0; e.maxIdx = '0; e.tieCnt = '0; e.negCnt = '0;
        e.err = (n == 0);
        e.latency = 1;
        if (n > 0) begin
            for (int i = 1; i < n; i++)
                if ($signed(wq[i]) > $signed(wq[e.maxIdx])) e.maxIdx = CNT_W'(i);
            e.maxVal = wq[e.maxIdx];
            for (int i = 0; i < n; i++) begin
                if (wq[i] == e.maxVal) e.tieCnt++;
                if (i > e.maxIdx && wq[i] != e.maxVal && abs17(wq[i]) == abs17(e.maxVal))
                    e.negCnt++;
            end
            e.latency = 1 + (n - 1) * (CMP_WAIT + 2) + ((bubble && n > 1) ? 1 : 0);
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sendWord(input logic [15:0] d, output int accCyc);
        inValid = 1'b1;
        inData  = d;
        for (int t = 0; t < 50 && inReady !== 1'b1; t++) @(negedge clk);
        checkOutput("ready_timeout", inReady, 1);
        accCyc = cycleCnt;
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic checkResults(input string name, input int lat);
        expT e;
        e = expQ.pop_front();
        checkOutput({name, "_maxVal"}, maxVal, e.maxVal);
        checkOutput({name, "_maxIdx"}, maxIdx, e.maxIdx);
        checkOutput({name, "_tieCnt"}, tieCnt, e.tieCnt);
        checkOutput({name, "_negCnt"}, negCnt, e.negCnt);
        checkOutput({name, "_err"}, err, e.err);
        checkOutput({name, "_busy"}, busy, 1);
        checkOutput({name, "_latency"}, lat, e.latency);
        @(negedge clk);
        checkOutput({name, "_donePulse"}, done, 0);
        checkOutput({name, "_idleBusy"}, busy, 0);
        checkOutput({name, "_holdMax"}, maxVal, e.maxVal);
    endtask

    task automatic applyStimulus(input string name, input int n, input bit bubble, input bit holdStart);
        int          accCyc;
        int          firstAcc;
        logic [15:0] runMax;
        expQ.push_back(computeExpected(n, bubble));
        @(negedge clk);
        start = 1'b1;
        len   = CNT_W'(n);
        firstAcc = cycleCnt;
        runMax = '0;
        @(negedge clk);
        if (holdStart) len = '0;
        else start = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (bubble && k == 1) begin
                inValid = 1'b0;
                @(negedge clk);
            end
            sendWord(wq[k], accCyc);
            if (k == 0) firstAcc = accCyc;
            if (k == n - 1) start = 1'b0;
            if (k > 0) begin
                for (int j = 0; j <= CMP_WAIT; j++) begin
                    checkOutput({name, "_readyLow"}, inReady, 0);
                    checkOutput({name, "_cmpA"}, cmpA, wq[k]);
                    checkOutput({name, "_cmpB"}, cmpB, runMax);
                    @(negedge clk);
                end
            end
            if (k == 0 || $signed(wq[k]) > $signed(runMax)) runMax = wq[k];
        end
        start = 1'b0;
        for (int t = 0; t < 100 && done !== 1'b1; t++) @(negedge clk);
        checkOutput({name, "_doneTimeout"}, done, 1);
        checkResults(name, cycleCnt - firstAcc);
    endtask

    initial begin
        int  acc;
        bit  sawDone;
        rst = 1'b1; start = 1'b0; len = '0; inValid = 1'b0; inData = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", inReady, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_maxVal", maxVal, 0);
        checkOutput("rst_cmpA", cmpA, 0);
        rst = 1'b0;

        // Abandon a search part-way through with a reset.
        @(negedge clk);
        start = 1'b1; len = 8'd5;
        @(negedge clk);
        start = 1'b0;
        sendWord(16'd9, acc);
        sendWord(16'd20, acc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_ready", inReady, 0);
        checkOutput("midrst_err", err, 0);
        checkOutput("midrst_maxVal", maxVal, 0);
        checkOutput("midrst_tieCnt", tieCnt, 0);
        checkOutput("midrst_cmpA", cmpA, 0);
        checkOutput("midrst_cmpB", cmpB, 0);
        sawDone = 1'b0;
        for (int t = 0; t < 12; t++) begin
            if (done === 1'b1) sawDone = 1'b1;
            @(negedge clk);
        end
        checkOutput("midrst_noDone", sawDone, 0);

        wq = {16'd3, 16'hFFF9, 16'd12, 16'd5};
        applyStimulus("basic", 4, 1'b0, 1'b0);

        wq = {16'hFFFB, 16'd5, 16'd5, 16'hFFFB, 16'd5};
        applyStimulus("ties", 5, 1'b0, 1'b0);

        wq = {};
        applyStimulus("lenZero", 0, 1'b0, 1'b0);

        wq = {16'h8000, 16'h7FFF, 16'h8000};
        applyStimulus("extremes", 3, 1'b1, 1'b0);

        wq = {16'hABCD};
        applyStimulus("single", 1, 1'b0, 1'b1);

        wq = {16'h8000, 16'h8000, 16'h8000};
        applyStimulus("minEq", 3, 1'b0, 1'b1);

        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
